// File: rtl/fifo_modport_pkg.sv
// Shared defaults and types for the single-clock parity-protected FIFO.
// The occupancy type counts 0..DEPTH inclusive, hence one extra bit.
package fifo_modport_pkg;

   localparam int DATA_WIDTH_DEF      = 32;
   localparam int ADDR_WIDTH_DEF      = 6;
   localparam int ALMOST_EMPTY_TH_DEF = 4;
   localparam int DEPTH               = 2 ** ADDR_WIDTH_DEF;

   typedef logic [ADDR_WIDTH_DEF:0] occ_t;

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: each word carries its data plus one stored parity bit in the MSB.
// Synchronous write, combinational read; contents are never reset.
module fifo_mem
   import fifo_modport_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  wr_en_i,
   input  logic [ADDR_WIDTH-1:0] wr_addr_i,
   input  logic [DATA_WIDTH:0]   wr_data_i,
   input  logic [ADDR_WIDTH-1:0] rd_addr_i,
   output logic [DATA_WIDTH:0]   rd_data_o
);

   logic [DATA_WIDTH:0] storage [2**ADDR_WIDTH];

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         storage[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_data_o = storage[rd_addr_i];

endmodule

// File: rtl/fifo_modport.sv
// Single-clock FIFO with per-entry even parity, error injection, a gated read
// side, and registered status flags derived from next-state pointers.
module fifo_modport
   import fifo_modport_pkg::*;
#(
   parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH      = ADDR_WIDTH_DEF,
   parameter int ALMOST_EMPTY_TH = ALMOST_EMPTY_TH_DEF
) (
   input  logic                  rd_clk,
   input  logic                  rd_rst_n,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  parity_inj,
   input  logic                  rd_en,
   input  logic                  rd_clk_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  empty,
   output logic                  almost_empty,
   output logic                  full,
   output logic                  underflow_err,
   output logic                  overflow_err,
   output logic                  parity_err,
   output logic [ADDR_WIDTH:0]   rd_occupancy
);

   localparam logic [ADDR_WIDTH:0] DepthCount    = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] AlmostEmptyTh = (ADDR_WIDTH+1)'(ALMOST_EMPTY_TH);

   logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   occ_q, occ_d;
   logic [DATA_WIDTH-1:0] rd_data_q;
   logic                  empty_q, almost_empty_q, full_q;
   logic                  underflow_q, overflow_q, parity_err_q;

   logic                  wrAccept, rdRequest, rdAccept;
   logic [DATA_WIDTH:0]   memWrWord, memRdWord;
   logic                  parityMismatch;

   // Acceptance uses the registered flags, so a read in the same cycle
   // never frees a slot for a write while full.
   always_comb begin
      wrAccept       = wr_en && !full_q;
      rdRequest      = rd_en && rd_clk_en;
      rdAccept       = rdRequest && !empty_q;
      wr_ptr_d       = wr_ptr_q + {{ADDR_WIDTH{1'b0}}, wrAccept};
      rd_ptr_d       = rd_ptr_q + {{ADDR_WIDTH{1'b0}}, rdAccept};
      occ_d          = wr_ptr_d - rd_ptr_d;
      memWrWord      = {(^wr_data) ^ parity_inj, wr_data};
      parityMismatch = (^memRdWord[DATA_WIDTH-1:0]) != memRdWord[DATA_WIDTH];
   end

   fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk       (rd_clk),
      .wr_en_i   (wrAccept),
      .wr_addr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
      .wr_data_i (memWrWord),
      .rd_addr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
      .rd_data_o (memRdWord)
   );

   always_ff @(posedge rd_clk or negedge rd_rst_n) begin
      if (!rd_rst_n) begin
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         occ_q          <= '0;
         rd_data_q      <= '0;
         empty_q        <= 1'b1;
         almost_empty_q <= 1'b1;
         full_q         <= 1'b0;
         underflow_q    <= 1'b0;
         overflow_q     <= 1'b0;
         parity_err_q   <= 1'b0;
      end else begin
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         occ_q          <= occ_d;
         empty_q        <= (occ_d == '0);
         almost_empty_q <= (occ_d <= AlmostEmptyTh);
         full_q         <= (occ_d == DepthCount);
         underflow_q    <= rdRequest && empty_q;
         overflow_q     <= wr_en && full_q;
         parity_err_q   <= rdAccept && parityMismatch;
         if (rdAccept) begin
            rd_data_q <= memRdWord[DATA_WIDTH-1:0];
         end
      end
   end

   assign rd_data       = rd_data_q;
   assign empty         = empty_q;
   assign almost_empty  = almost_empty_q;
   assign full          = full_q;
   assign underflow_err = underflow_q;
   assign overflow_err  = overflow_q;
   assign parity_err    = parity_err_q;
   assign rd_occupancy  = occ_q;

endmodule

// File: tb/tb_fifo_modport.sv
// Directed self-checking bench for fifo_modport with hand-computed expectations.
module tb_fifo_modport;

   logic        rd_clk = 1'b0;
   logic        rd_rst_n;
   logic        wr_en;
   logic [31:0] wr_data;
   logic        parity_inj;
   logic        rd_en;
   logic        rd_clk_en;
   logic [31:0] rd_data;
   logic        empty, almost_empty, full;
   logic        underflow_err, overflow_err, parity_err;
   logic [6:0]  rd_occupancy;

   int checks   = 0;
   int failures = 0;

   fifo_modport dut (
      .rd_clk        (rd_clk),
      .rd_rst_n      (rd_rst_n),
      .wr_en         (wr_en),
      .wr_data       (wr_data),
      .parity_inj    (parity_inj),
      .rd_en         (rd_en),
      .rd_clk_en     (rd_clk_en),
      .rd_data       (rd_data),
      .empty         (empty),
      .almost_empty  (almost_empty),
      .full          (full),
      .underflow_err (underflow_err),
      .overflow_err  (overflow_err),
      .parity_err    (parity_err),
      .rd_occupancy  (rd_occupancy)
   );

   always #5 rd_clk = ~rd_clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Inputs are driven 1 time unit after an edge and outputs sampled 1 after the next.
   task automatic applyStimulus(input logic we, input logic [31:0] wd, input logic pi,
                                input logic re, input logic rce);
      wr_en      = we;
      wr_data    = wd;
      parity_inj = pi;
      rd_en      = re;
      rd_clk_en  = rce;
      @(posedge rd_clk);
      #1;
   endtask

   initial begin
      rd_rst_n   = 1'b0;
      wr_en      = 1'b0;
      wr_data    = 32'h0;
      parity_inj = 1'b0;
      rd_en      = 1'b0;
      rd_clk_en  = 1'b0;
      #12;
      checkOutput("rst_empty",     32'(empty), 32'd1);
      checkOutput("rst_aempty",    32'(almost_empty), 32'd1);
      checkOutput("rst_full",      32'(full), 32'd0);
      checkOutput("rst_occ",       32'(rd_occupancy), 32'd0);
      checkOutput("rst_rdata",     rd_data, 32'd0);
      checkOutput("rst_errs",      32'({underflow_err, overflow_err, parity_err}), 32'd0);
      rd_rst_n = 1'b1;

      // Underflow from empty, then a gated read that must not underflow
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      checkOutput("uf_pulse",      32'(underflow_err), 32'd1);
      checkOutput("uf_empty",      32'(empty), 32'd1);
      checkOutput("uf_occ",        32'(rd_occupancy), 32'd0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      checkOutput("uf_gated",      32'(underflow_err), 32'd0);

      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 32'h11 + i, 1'b0, 1'b0, 1'b0);
         checkOutput("w5_occ",     32'(rd_occupancy), i + 1);
         checkOutput("w5_aempty",  32'(almost_empty), 32'((i + 1) <= 4));
         checkOutput("w5_empty",   32'(empty), 32'd0);
      end
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
         checkOutput("r5_data",    rd_data, 32'h11 + i);
         checkOutput("r5_occ",     32'(rd_occupancy), 4 - i);
         checkOutput("r5_aempty",  32'(almost_empty), 32'd1);
      end
      checkOutput("r5_empty",      32'(empty), 32'd1);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      checkOutput("hold_rdata",    rd_data, 32'h15);

      // Read side disabled at occupancy 3
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h21 + i, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
         checkOutput("ce_rdata",   rd_data, 32'h15);
         checkOutput("ce_uf",      32'(underflow_err), 32'd0);
         checkOutput("ce_occ",     32'(rd_occupancy), 32'd3);
      end
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
         checkOutput("ce_drain",   rd_data, 32'h21 + i);
      end

      // Fill to depth, overflow, and write rejected while full even with a read
      for (int i = 0; i < 64; i++) applyStimulus(1'b1, 32'h1000 + i, 1'b0, 1'b0, 1'b0);
      checkOutput("fill_full",     32'(full), 32'd1);
      checkOutput("fill_occ",      32'(rd_occupancy), 32'd64);
      checkOutput("fill_aempty",   32'(almost_empty), 32'd0);
      applyStimulus(1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b0);
      checkOutput("of_pulse",      32'(overflow_err), 32'd1);
      checkOutput("of_occ",        32'(rd_occupancy), 32'd64);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      checkOutput("of_clear",      32'(overflow_err), 32'd0);
      applyStimulus(1'b1, 32'hBEEF, 1'b0, 1'b1, 1'b1);
      checkOutput("ofrd_pulse",    32'(overflow_err), 32'd1);
      checkOutput("ofrd_data",     rd_data, 32'h1000);
      checkOutput("ofrd_occ",      32'(rd_occupancy), 32'd63);
      checkOutput("ofrd_full",     32'(full), 32'd0);
      for (int i = 0; i < 63; i++) begin
         applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
         checkOutput("full_drain", rd_data, 32'h1001 + i);
      end
      checkOutput("drain_empty",   32'(empty), 32'd1);

      // Parity injection on the middle word only
      applyStimulus(1'b1, 32'h5A5A0001, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h5A5A0003, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      checkOutput("par1_data",     rd_data, 32'h5A5A0001);
      checkOutput("par1_err",      32'(parity_err), 32'd0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      checkOutput("par2_data",     rd_data, 32'hA5A5A5A5);
      checkOutput("par2_err",      32'(parity_err), 32'd1);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      checkOutput("par3_data",     rd_data, 32'h5A5A0003);
      checkOutput("par3_err",      32'(parity_err), 32'd0);

      // Steady-state streaming across the pointer wrap
      for (int i = 0; i < 40; i++) applyStimulus(1'b1, 32'h4000 + i, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 200; k++) begin
         applyStimulus(1'b1, 32'h4000 + 40 + k, 1'b0, 1'b1, 1'b1);
         checkOutput("stream_data", rd_data, 32'h4000 + k);
         checkOutput("stream_occ",  32'(rd_occupancy), 32'd40);
      end

      // Asynchronous reset mid-operation
      #2;
      rd_rst_n = 1'b0;
      #1;
      checkOutput("arst_occ",      32'(rd_occupancy), 32'd0);
      checkOutput("arst_empty",    32'(empty), 32'd1);
      checkOutput("arst_aempty",   32'(almost_empty), 32'd1);
      checkOutput("arst_rdata",    rd_data, 32'd0);
      #1;
      rd_rst_n = 1'b1;

      // Read and write together while empty
      applyStimulus(1'b1, 32'h77, 1'b0, 1'b1, 1'b1);
      checkOutput("rwe_uf",        32'(underflow_err), 32'd1);
      checkOutput("rwe_occ",       32'(rd_occupancy), 32'd1);
      checkOutput("rwe_empty",     32'(empty), 32'd0);
      checkOutput("rwe_rdata",     rd_data, 32'd0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      checkOutput("rwe_read",      rd_data, 32'h77);
      checkOutput("rwe_uf_clr",    32'(underflow_err), 32'd0);
      checkOutput("rwe_empty2",    32'(empty), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
